lift_controller: RTL and testbench
==================================

// Module: lift_controller
// PURPOSE
//  Single-car lift scheduler. It latches floor requests, moves the car one floor at a time and
//  times the door. It produces the 3-bit current floor that drives lift_floor_indicator directly
//  downstream: floor -> 7-seg.
//  The scan (elevator) policy keeps the current direction while requests remain ahead, then reverses.
// PARAMETERS
//  NUM_FLOORS     8    number of floors, 2..8; floors are 0..NUM_FLOORS-1
//  FLOOR_W        3    width of floor output; must satisfy 2**FLOOR_W >= NUM_FLOORS
//  TRAVEL_CYCLES  16   clock cycles to travel one floor, >=2
//  DOOR_CYCLES    32   clock cycles the door stays open, >=2
// PORTS
//  clk         in   1           single system clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  req         in   NUM_FLOORS  request pulses, one bit per floor (car and hall merged); may be held
//  floor       out  FLOOR_W     current floor, registered; feeds lift_floor_indicator.floor
//  dir_up      out  1           1 = last/current travel direction is up
//  moving      out  1           1 while in MOVE_UP or MOVE_DOWN
//  door_open   out  1           1 while in DOOR_OPEN
//  pending     out  NUM_FLOORS  latched outstanding requests
//  door_hold   in   1           present only with LIFT_DOOR_HOLD_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//   - floor=0, dir_up=1, moving=0, door_open=0, pending=0, state=IDLE, timer=0
//   - A reset asserted mid-move or with the door open discards all requests and returns the car to floor 0 at once.
//  Request latching: pending <= (pending | req) & ~clr each cycle.
//   - clr is the one-hot bit of a floor being served this cycle.
//   - When req and clr hit the same bit in the same cycle, clear wins; the request counts as served.
//  States:
//   - IDLE
//     - pending[floor]=1 -> DOOR_OPEN next cycle; clear that bit.
//     - Otherwise, requests both above and below -> move in direction dir_up.
//     - Requests only above -> MOVE_UP. Requests only below -> MOVE_DOWN.
//     - Nothing pending -> stay in IDLE.
//   - MOVE_UP / MOVE_DOWN
//     - The timer counts 0..TRAVEL_CYCLES-1. At TRAVEL_CYCLES-1, floor steps by +/-1 and the timer returns to 0.
//     - In that same cycle: if pending[new floor] -> DOOR_OPEN and clear the bit.
//     - Else, requests still ahead -> continue moving. Else -> IDLE.
//     - dir_up is updated on entry to MOVE_UP/MOVE_DOWN.
//   - DOOR_OPEN
//     - The timer counts 0..DOOR_CYCLES-1, then the state goes to IDLE.
//     - A req for the current floor during DOOR_OPEN restarts the timer at 0 and is cleared, not latched.
//  Timing:
//   - floor never changes mid-travel, so the indicator shows only whole floors.
//   - A request for a floor the car is between does not stop the car; it is served on a later pass.
//   - Latency from IDLE: a request to floor cur+k opens the door 1 + k*TRAVEL_CYCLES cycles after the req cycle.
//  Bounds and invariants:
//   - floor saturates by construction: no MOVE_UP at NUM_FLOORS-1, no MOVE_DOWN at 0.
//   - moving and door_open are never both 1.
//   - req bits at or above NUM_FLOORS do not exist; FLOOR_W bits above the range stay 0.
// CONFIGURATION
//  LIFT_DOOR_HOLD_EN
//   - Defined: adds the door_hold input. While door_hold=1 in DOOR_OPEN, the door timer is held at 0 and the door stays open.
//   - door_hold has no effect in other states.
//   - Undefined: the port is absent and the door closes exactly DOOR_CYCLES cycles after opening or the last restart.
// STRUCTURE
//  - lift_pkg.vh: state encodings IDLE/MOVE_UP/MOVE_DOWN/DOOR_OPEN as localparams, plus default NUM_FLOORS/FLOOR_W.
//    Shared with future lift blocks.
//  - Sub-module lift_timer: loadable up-counter with clear, hold and terminal-count flag.
//    One instance serves both travel and door timing, with the terminal value muxed by state.
//  - The top holds the FSM, the pending register and the scan-direction logic.
// TESTING (bench: TRAVEL_CYCLES=4, DOOR_CYCLES=6)
//  - Reset mid-move at floor 3 -> next cycle floor=0, pending=0, moving=0, door_open=0.
//  - Idle at 0, pulse req[3] -> moving=1 next cycle; floor 1,2,3 every 4 cycles.
//    door_open=1 at cycle 13, held 6 cycles, then IDLE; pending[3]=0.
//  - Car at 2 moving up toward 5, req[1] and req[4] pulsed.
//    -> stops at 4, then 5, then reverses and serves 1.
//    dir_up goes 1->0 after floor 5; the floor sequence never skips a floor.
//  - Door open at floor 2, req[2] pulsed at timer=4 -> timer restarts; door_open lasts 11 cycles total; pending[2] stays 0.
//  - Idle at 7, req[7] held high and req[0] pulsed -> door opens at 7 without moving.
//    Then the car moves down to 0; floor never exceeds 7 and never wraps.
//  - With LIFT_DOOR_HOLD_EN: door_hold=1 for 20 cycles during DOOR_OPEN -> door_open stays 1 throughout, then closes 6 cycles after release.

Source files
------------

// File: rtl/lift_pkg.sv
// lift_pkg: shared definitions for the lift blocks.
//   lift_state_t     scheduler state encoding (IDLE / MOVE_UP / MOVE_DOWN / DOOR_OPEN)
//   LIFT_NUM_FLOORS  default number of floors served by one car
//   LIFT_FLOOR_W     default width of a floor number
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } lift_state_t;

  localparam int LIFT_NUM_FLOORS = 8;
  localparam int LIFT_FLOOR_W    = 3;

endpackage

// File: rtl/lift_timer.sv
// lift_timer: up-counter shared by travel and door timing.
//   Counts 0..term, flags the terminal value on tc and wraps to 0 on the
//   following edge. clr forces the count to 0 (wins over everything but
//   reset); hold freezes the count.
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      synchronous active-high reset
//   clr   in   1      restart count at 0
//   hold  in   1      freeze count
//   term  in   CNT_W  terminal value (last count before wrap)
//   tc    out  1      count == term
module lift_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lift_controller.sv
// lift_controller: single-car scan scheduler.
//   Latches floor requests, moves the car one floor per TRAVEL_CYCLES and
//   keeps the door open for DOOR_CYCLES. The car keeps its direction while
//   requests remain ahead, then reverses.
// Optional feature: define LIFT_DOOR_HOLD_EN to add the door_hold input,
//   which keeps the door open (timer held at 0) while asserted in DOOR_OPEN.
// Ports:
//   clk        in   1           system clock, rising edge
//   rst        in   1           synchronous active-high reset
//   req        in   NUM_FLOORS  request pulses, one bit per floor
//   door_hold  in   1           (LIFT_DOOR_HOLD_EN only) hold door open
//   floor      out  FLOOR_W     current floor, registered
//   dir_up     out  1           last/current travel direction is up
//   moving     out  1           car travelling between floors
//   door_open  out  1           door open
//   pending    out  NUM_FLOORS  latched outstanding requests
module lift_controller
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = LIFT_NUM_FLOORS,
  parameter int FLOOR_W       = LIFT_FLOOR_W,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  lift_state_t             state_q, state_d;
  logic [FLOOR_W-1:0]      floor_d;
  logic                    dir_d;
  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   eff;
  logic [FLOOR_W-1:0]      nf;
  logic                    here_cur, above_cur, below_cur;
  logic                    here_nf, above_nf, below_nf;
  logic                    tmr_clr, tmr_hold, tmr_tc;
  logic [CNT_W-1:0]        tmr_term;

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(f)) b[i] = 1'b1;
    end
    return b;
  endfunction

  // A request arriving this cycle is acted on immediately, not a cycle late.
  assign eff = pending | req;

  // Request position relative to the current floor and to the floor the car
  // reaches at the end of the present travel step.
  always_comb begin
    nf        = (state_q == MOVE_DOWN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
    here_cur  = 1'b0;
    above_cur = 1'b0;
    below_cur = 1'b0;
    here_nf   = 1'b0;
    above_nf  = 1'b0;
    below_nf  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (eff[i]) begin
        if (i == int'(floor)) here_cur  = 1'b1;
        if (i >  int'(floor)) above_cur = 1'b1;
        if (i <  int'(floor)) below_cur = 1'b1;
        if (i == int'(nf))    here_nf   = 1'b1;
        if (i >  int'(nf))    above_nf  = 1'b1;
        if (i <  int'(nf))    below_nf  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor;
    dir_d    = dir_up;
    clr      = '0;
    tmr_clr  = 1'b0;
    tmr_hold = 1'b0;
    tmr_term = CNT_W'(TRAVEL_CYCLES - 1);
    case (state_q)
      IDLE: begin
        // Timer sits at 0 so travel/door timing starts cleanly on exit.
        tmr_hold = 1'b1;
        if (here_cur) begin
          state_d = DOOR_OPEN;
          clr     = floor_bit(floor);
        end else if (above_cur && below_cur) begin
          state_d = dir_up ? MOVE_UP : MOVE_DOWN;
        end else if (above_cur) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (below_cur) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (tmr_tc) begin
          floor_d = nf;
          if (here_nf) begin
            state_d = DOOR_OPEN;
            clr     = floor_bit(nf);
          end else if ((state_q == MOVE_UP) ? above_nf : below_nf) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        tmr_term = CNT_W'(DOOR_CYCLES - 1);
        // pending[floor] is always clear here, so here_cur means req[floor].
        if (here_cur) begin
          tmr_clr = 1'b1;
          clr     = floor_bit(floor);
`ifdef LIFT_DOOR_HOLD_EN
        end else if (door_hold) begin
          tmr_clr = 1'b1;
`endif
        end else if (tmr_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      floor   <= '0;
      dir_up  <= 1'b1;
      pending <= '0;
    end else begin
      state_q <= state_d;
      floor   <= floor_d;
      dir_up  <= dir_d;
      pending <= eff & ~clr;
    end
  end

  lift_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .hold (tmr_hold),
    .term (tmr_term),
    .tc   (tmr_tc)
  );

  assign moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign door_open = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_lift_controller.sv
// tb_lift_controller: bench for lift_controller (TRAVEL_CYCLES=4, DOOR_CYCLES=6).
// A behavioural model tracks floor, direction, activity and remaining cycles
// and is compared with the DUT every cycle; directed scenarios add explicit
// latency, ordering and boundary checks, followed by random requests.
module tb_lift_controller;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 6;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_DOOR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NF-1:0] req = '0;
  logic [FW-1:0] cur_floor;
  logic          dir_up, moving, door_open;
  logic [NF-1:0] pending;
  bit            hold_drv = 1'b0;
`ifdef LIFT_DOOR_HOLD_EN
  logic          door_hold = 1'b0;
`endif

  lift_controller #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .floor     (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain state of the car plus cycles left in the
  // current travel step or door interval.
  int          m_floor, m_mode, m_left;
  bit          m_dir;
  bit [NF-1:0] m_pend;

  function automatic bit any_beyond(bit [NF-1:0] v, int f, bit up);
    for (int i = 0; i < NF; i++)
      if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit [NF-1:0] r, input bit rs, input bit hold);
    bit [NF-1:0] eff;
    int          served;
    bit          a, b;
    if (rs) begin
      m_floor = 0; m_mode = M_IDLE; m_left = 0; m_dir = 1'b1; m_pend = '0;
      return;
    end
    eff    = m_pend | r;
    served = -1;
    case (m_mode)
      M_IDLE: begin
        if (eff[m_floor]) begin
          m_mode = M_DOOR; m_left = DC; served = m_floor;
        end else begin
          a = any_beyond(eff, m_floor, 1'b1);
          b = any_beyond(eff, m_floor, 1'b0);
          if (a || b) begin
            if (!(a && b)) m_dir = a;
            m_mode = m_dir ? M_UP : M_DN;
            m_left = TC;
          end
        end
      end
      M_UP, M_DN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_mode == M_UP) ? 1 : -1;
          if (eff[m_floor]) begin
            m_mode = M_DOOR; m_left = DC; served = m_floor;
          end else if (any_beyond(eff, m_floor, m_mode == M_UP)) begin
            m_left = TC;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        if (r[m_floor]) begin
          m_left = DC; served = m_floor;
        end else if (hold) begin
          m_left = DC;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    if (served >= 0) eff[served] = 1'b0;
    m_pend = eff;
  endtask

  // One clock: drive inputs, advance DUT and model, compare all outputs.
  task automatic tick(input logic [NF-1:0] r, input logic rs);
    req = r;
    rst = rs;
`ifdef LIFT_DOOR_HOLD_EN
    door_hold = hold_drv;
`endif
    @(posedge clk);
    #1;
    model_step(r, rs, hold_drv);
    chk("floor",     int'(cur_floor), m_floor);
    chk("dir_up",    int'(dir_up),    int'(m_dir));
    chk("moving",    int'(moving),    int'(m_mode == M_UP || m_mode == M_DN));
    chk("door_open", int'(door_open), int'(m_mode == M_DOOR));
    chk("pending",   int'(pending),   int'(m_pend));
    chk("excl",      int'(moving && door_open), 0);
    req = '0;
    rst = 1'b0;
  endtask

  // kind 0: door open; 1: door closed; 2: moving at floor arg
  task automatic wait_for(input string tag, input int kind, input int arg);
    bit hit;
    int n;
    n = 0;
    hit = 1'b0;
    while (n < 500) begin
      hit = (kind == 0) ? door_open :
            (kind == 1) ? !door_open :
                          (int'(cur_floor) == arg && moving);
      if (hit) break;
      tick('0, 1'b0);
      n++;
    end
    chk(tag, int'(hit), 1);
  endtask

  initial begin
    int n, d, prevf, df, fall_floor, ns, maxf;
    int seq [3];
    bit prev_dir, prev_door;
    logic [NF-1:0] r;

    // Reset values
    tick('0, 1'b1);
    chk("rst_floor", int'(cur_floor), 0);
    chk("rst_dir",   int'(dir_up), 1);
    chk("rst_move",  int'(moving), 0);
    chk("rst_door",  int'(door_open), 0);
    chk("rst_pend",  int'(pending), 0);

    // Idle at 0, request floor 3: latency and door length
    tick(NF'(1) << 3, 1'b0);
    chk("lat_moving", int'(moving), 1);
    n = 1; prevf = 0;
    while (!door_open && n < 100) begin
      tick('0, 1'b0);
      n++;
      if (int'(cur_floor) != prevf) begin
        chk("step_time", n, 1 + TC * int'(cur_floor));
        prevf = int'(cur_floor);
      end
    end
    chk("lat_door",  n, 13);
    chk("lat_floor", int'(cur_floor), 3);
    d = 0;
    while (door_open && d < 100) begin
      d++;
      tick('0, 1'b0);
    end
    chk("door_len", d, DC);
    chk("served3",  int'(pending[3]), 0);

    // Reset mid-move at floor 3
    tick('0, 1'b1);
    tick(NF'(1) << 6, 1'b0);
    wait_for("to_f3", 2, 3);
    tick('0, 1'b1);
    chk("mrst_floor", int'(cur_floor), 0);
    chk("mrst_pend",  int'(pending), 0);
    chk("mrst_move",  int'(moving), 0);
    chk("mrst_door",  int'(door_open), 0);

    // Scan order: moving up at 2 toward 5, then requests for 1 and 4
    tick('0, 1'b1);
    tick(NF'(1) << 5, 1'b0);
    wait_for("to_f2", 2, 2);
    tick((NF'(1) << 1) | (NF'(1) << 4), 1'b0);
    seq = '{-1, -1, -1};
    ns = 0; fall_floor = -1; n = 0;
    prevf = int'(cur_floor); prev_dir = dir_up; prev_door = door_open;
    while (n < 400 && (moving || door_open || pending != '0)) begin
      tick('0, 1'b0);
      n++;
      if (door_open && !prev_door && ns < 3) begin
        seq[ns] = int'(cur_floor);
        ns++;
      end
      if (prev_dir && !dir_up) fall_floor = int'(cur_floor);
      if (int'(cur_floor) != prevf) begin
        df = int'(cur_floor) - prevf;
        chk("no_skip", int'(df == 1 || df == -1), 1);
      end
      prevf = int'(cur_floor); prev_dir = dir_up; prev_door = door_open;
    end
    chk("scan_1st", seq[0], 4);
    chk("scan_2nd", seq[1], 5);
    chk("scan_3rd", seq[2], 1);
    chk("rev_floor", fall_floor, 5);

    // Door restart at floor 2: req[2] while timer is 4
    tick('0, 1'b1);
    tick(NF'(1) << 2, 1'b0);
    wait_for("door_f2", 0, 0);
    d = 0;
    while (door_open && d < 100) begin
      d++;
      tick((d == 5) ? (NF'(1) << 2) : NF'(0), 1'b0);
      if (d == 5) chk("restart_pend", int'(pending[2]), 0);
    end
    chk("restart_len", d, 11);

    // Top floor: idle at 7, req[7] held with req[0] pulsed
    tick('0, 1'b1);
    tick(NF'(1) << 7, 1'b0);
    wait_for("door_f7", 0, 0);
    wait_for("close_f7", 1, 0);
    tick((NF'(1) << 7) | NF'(1), 1'b0);
    chk("top_door",  int'(door_open), 1);
    chk("top_floor", int'(cur_floor), 7);
    for (int k = 0; k < 3; k++) tick(NF'(1) << 7, 1'b0);
    maxf = 0; n = 0;
    while (n < 300 && !(door_open && cur_floor == '0)) begin
      tick('0, 1'b0);
      n++;
      if (int'(cur_floor) > maxf) maxf = int'(cur_floor);
    end
    chk("bottom_floor", int'(cur_floor), 0);
    chk("max_floor", maxf, 7);

`ifdef LIFT_DOOR_HOLD_EN
    // Door hold for 20 cycles, then normal close
    tick('0, 1'b1);
    tick(NF'(1) << 1, 1'b0);
    wait_for("door_f1", 0, 0);
    hold_drv = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick('0, 1'b0);
      chk("hold_open", int'(door_open), 1);
    end
    hold_drv = 1'b0;
    d = 0;
    while (door_open && d < 100) begin
      d++;
      tick('0, 1'b0);
    end
    chk("hold_release", d, DC);
`endif

    // Random traffic against the model
    tick('0, 1'b1);
    r = '0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) != 0) r = '0;
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
`ifdef LIFT_DOOR_HOLD_EN
      hold_drv = ($urandom_range(0, 9) == 0);
`endif
      tick(r, ($urandom_range(0, 499) == 0));
    end
    hold_drv = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
